// File: rtl/param_frame_buffer.sv
// Single-frame buffer: fills a word memory through a valid/ready input, then replays it in
// address order through a registered valid/ready output. Define BUFFER_REPLAY_EN to add the replay input.
module param_frame_buffer #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 22500,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic              mode,
`ifdef BUFFER_REPLAY_EN
  input  logic              replay,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              complete,
  output logic              overflow,
  output logic [2:0]        state_dbg
);

  // Handshakes: a word moves on a rising edge where valid & ready are both high; a presented
  // out_valid/out_data pair never changes until it moves, except on reset or abort.

  typedef enum logic [2:0] {IDLE, FILL, FULL, DRAIN, DONE} state_t;

  localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];
  logic [ADDR_W:0]   rd_addr;
  logic              wr_fire, out_fire, last_out, load, replay_req;

`ifdef BUFFER_REPLAY_EN
  assign replay_req = replay;
`else
  assign replay_req = 1'b0;
`endif

  assign in_ready  = (state == FILL) & enb & (level < DEPTH_L);
  assign wr_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  // rd_addr already points past the presented word, so rd_addr == level marks the final word.
  assign last_out  = out_fire & (rd_addr == level);
  assign load      = (state == DRAIN) & mode & enb & (rd_addr != level) & (~out_valid | out_ready);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (enb) state_nxt = mode ? DRAIN : FILL;
      FILL: begin
        if (mode)                                        state_nxt = DRAIN;
        else if (wr_fire && (level + 1'b1) == DEPTH_L)   state_nxt = FULL;
      end
      FULL:  if (mode) state_nxt = DRAIN;
      DRAIN: begin
        if (!mode)                                           state_nxt = IDLE;
        else if (last_out || (!out_valid && rd_addr == level)) state_nxt = DONE;
      end
      DONE: begin
        if (!mode)           state_nxt = IDLE;
        else if (replay_req) state_nxt = DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage is deliberately left out of reset; a reset simply forgets the frame via level.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[level[MEM_AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level     <= '0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      complete  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (state == FULL && in_valid) overflow <= 1'b1;
      if (state != DRAIN) rd_addr <= '0;
      case (state)
        FILL: if (wr_fire) level <= level + 1'b1;
        DRAIN: begin
          if (!mode) begin
            out_valid <= 1'b0;
            level     <= '0;
            complete  <= 1'b0;
          end else begin
            if (load) begin
              out_data  <= mem[rd_addr[MEM_AW-1:0]];
              out_valid <= 1'b1;
              rd_addr   <= rd_addr + 1'b1;
            end else if (out_fire) begin
              out_valid <= 1'b0;
            end
            if (state_nxt == DONE) complete <= 1'b1;
          end
        end
        DONE: begin
          if (!mode) begin
            complete <= 1'b0;
            level    <= '0;
          end else if (replay_req) begin
            complete <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
